// File: rtl/fft_frame_ping_pong_buf.sv
// Two-bank ping-pong frame buffer: one bank fills from the input stream
// while the other is drained. Frames are read out oldest-first.
module fft_frame_ping_pong_buf #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*2*DATA_W-1:0]   in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic                       rd_en,
    output logic [N_CH*2*DATA_W-1:0]   out_data,
    output logic                       out_valid,
    output logic                       out_last,
    output logic                       rd_start_ready,
    output logic                       frame_avail,
    output logic [15:0]                drop_cnt,
    output logic                       len_err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned WW        = N_CH * 2 * DATA_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FULL, ST_READ} bank_st_t;

    bank_st_t          r_st [2];
    logic              r_wr_sel, r_wr_bank, r_rd_sel, r_discard;
    logic [AW-1:0]     r_wr_addr, r_rd_addr;
    logic              r_out_valid, r_out_last, r_rdy, r_avail, r_len_err;
    logic [15:0]       r_drop_cnt;
    logic [WW-1:0]     r_out_data;
    logic [WW-1:0]     r_mem0 [DEPTH];
    logic [WW-1:0]     r_mem1 [DEPTH];

    bank_st_t          w_st_n [2];
    logic              w_wr_sel_n, w_wr_bank_n, w_rd_sel_n, w_discard_n;
    logic [AW-1:0]     w_wr_addr_n, w_rd_addr_n;
    logic              w_rdy_n, w_avail_n, w_len_err_n;
    logic [15:0]       w_drop_cnt_n;
    logic              w_rd_fire, w_rd_busy, w_filling;
    logic              w_mem_we, w_mem_bank;
    logic [AW-1:0]     w_mem_addr;

    function automatic logic is_busy(input bank_st_t s);
        return (s == ST_FULL) || (s == ST_READ);
    endfunction

    // Next-state for bank states, pointers, counters and RAM write strobe
    always_comb begin
        w_st_n[0]    = r_st[0];
        w_st_n[1]    = r_st[1];
        w_wr_sel_n   = r_wr_sel;
        w_wr_bank_n  = r_wr_bank;
        w_rd_sel_n   = r_rd_sel;
        w_discard_n  = r_discard;
        w_wr_addr_n  = r_wr_addr;
        w_rd_addr_n  = r_rd_addr;
        w_rdy_n      = 1'b0;
        w_len_err_n  = r_len_err;
        w_drop_cnt_n = r_drop_cnt;
        w_mem_we     = 1'b0;
        w_mem_bank   = r_wr_bank;
        w_mem_addr   = r_wr_addr;
        w_rd_busy    = is_busy(r_st[r_rd_sel]);
        w_rd_fire    = rd_en && w_rd_busy;
        w_filling    = (r_st[r_wr_bank] == ST_FILL);

        // Read side: only ever touches the bank at r_rd_sel
        if (w_rd_fire) begin
            if (r_st[r_rd_sel] == ST_FULL) begin
                w_st_n[r_rd_sel] = ST_READ;
            end
            if (r_rd_addr == LAST_ADDR) begin
                w_st_n[r_rd_sel] = ST_EMPTY;
                w_rd_addr_n      = '0;
                w_rd_sel_n       = !r_rd_sel;
            end else begin
                w_rd_addr_n = r_rd_addr + AW'(1);
            end
        end

        // Write side: only ever touches an EMPTY or FILL bank
        if (in_valid) begin
            if (r_discard) begin
                if (in_last) begin
                    w_discard_n = 1'b0;
                end
            end else if (w_filling) begin
                w_mem_we = 1'b1;
                if (r_wr_addr == LAST_ADDR) begin
                    w_wr_addr_n = '0;
                    if (in_last) begin
                        w_st_n[r_wr_bank] = ST_FULL;
                        w_rdy_n           = 1'b1;
                        if (!w_rd_busy) begin
                            w_rd_sel_n = r_wr_bank;
                        end
                    end else begin
                        w_st_n[r_wr_bank] = ST_EMPTY;
                        w_len_err_n       = 1'b1;
                        w_discard_n       = 1'b1;
                    end
                end else if (in_last) begin
                    w_st_n[r_wr_bank] = ST_EMPTY;
                    w_len_err_n       = 1'b1;
                    w_wr_addr_n       = '0;
                end else begin
                    w_wr_addr_n = r_wr_addr + AW'(1);
                end
            end else if ((r_st[r_wr_sel] == ST_EMPTY) || (r_st[!r_wr_sel] == ST_EMPTY)) begin
                w_mem_bank  = (r_st[r_wr_sel] == ST_EMPTY) ? r_wr_sel : !r_wr_sel;
                w_mem_addr  = '0;
                w_mem_we    = 1'b1;
                w_wr_bank_n = w_mem_bank;
                w_wr_sel_n  = !w_mem_bank;
                if (in_last) begin
                    w_len_err_n = 1'b1;
                    w_wr_addr_n = '0;
                end else begin
                    w_st_n[w_mem_bank] = ST_FILL;
                    w_wr_addr_n        = AW'(1);
                end
            end else begin
                if (r_drop_cnt != 16'hFFFF) begin
                    w_drop_cnt_n = r_drop_cnt + 16'd1;
                end
                if (!in_last) begin
                    w_discard_n = 1'b1;
                end
            end
        end

        w_avail_n = is_busy(w_st_n[0]) || is_busy(w_st_n[1]);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st[0]     <= ST_EMPTY;
            r_st[1]     <= ST_EMPTY;
            r_wr_sel    <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_discard   <= 1'b0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_rdy       <= 1'b0;
            r_avail     <= 1'b0;
            r_len_err   <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_st[0]     <= w_st_n[0];
            r_st[1]     <= w_st_n[1];
            r_wr_sel    <= w_wr_sel_n;
            r_wr_bank   <= w_wr_bank_n;
            r_rd_sel    <= w_rd_sel_n;
            r_discard   <= w_discard_n;
            r_wr_addr   <= w_wr_addr_n;
            r_rd_addr   <= w_rd_addr_n;
            r_out_valid <= w_rd_fire;
            r_out_last  <= w_rd_fire && (r_rd_addr == LAST_ADDR);
            if (w_rd_fire) begin
                r_out_data <= r_rd_sel ? r_mem1[r_rd_addr] : r_mem0[r_rd_addr];
            end
            r_rdy       <= w_rdy_n;
            r_avail     <= w_avail_n;
            r_len_err   <= w_len_err_n;
            r_drop_cnt  <= w_drop_cnt_n;
        end
    end

    // Bank RAM writes; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            if (w_mem_bank) begin
                r_mem1[w_mem_addr] <= in_data;
            end else begin
                r_mem0[w_mem_addr] <= in_data;
            end
        end
    end

    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign out_last       = r_out_last;
    assign rd_start_ready = r_rdy;
    assign frame_avail    = r_avail;
    assign drop_cnt       = r_drop_cnt;
    assign len_err        = r_len_err;

endmodule
